// File: rtl/ones_count_feeder.sv
// Sequencer between a valid/ready word stream, a start/rdy bit-ones counter and a valid/ready result stream.
// Optional statistics outputs are built when FEEDER_STATS_EN is defined.
module ones_count_feeder #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cu_start,
    output logic [DATA_W-1:0] cu_data,
    input  logic              cu_rdy,
    input  logic [CNT_W-1:0]  cu_cnt,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_cnt,
    input  logic              out_ready
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]       stat_words,
    output logic [23:0]       stat_ones
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ISSUE   = 5'b00010,
        WAIT_LO = 5'b00100,
        WAIT_HI = 5'b01000,
        OUT     = 5'b10000
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic [OCC_W-1:0]  count_nxt;
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready;
    assign pop  = (state == IDLE) && (count != '0) && cu_rdy;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + OCC_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - OCC_W'(1);
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            in_ready <= (count_nxt != OCC_W'(FIFO_DEPTH));
        end
    end

    // Job sequencer: one word in flight from pop until the result is accepted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cu_start  <= 1'b0;
            cu_data   <= '0;
            out_valid <= 1'b0;
            out_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cu_data  <= mem[rd_ptr];
                        cu_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cu_start <= 1'b0;
                    state    <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!cu_rdy) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (cu_rdy) begin
                        out_cnt   <= cu_cnt;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cu_start  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stat_words <= '0;
            stat_ones  <= '0;
        end else if ((state == OUT) && out_valid && out_ready) begin
            stat_words <= stat_words + 16'(1);
            stat_ones  <= stat_ones + 24'(out_cnt);
        end
    end
`endif

endmodule
